// File: rtl/tick_timer_bank.sv
// Bank of independent programmable tick timers with periodic/one-shot modes,
// per-channel pause, and registered 50%-duty square outputs.
module tick_timer_bank #(
   parameter int unsigned N_CH           = 4,
   parameter int unsigned MAX_PERIOD     = 27000000,
   parameter int unsigned DEFAULT_PERIOD = 13500000,
   localparam int unsigned CW            = $clog2(MAX_PERIOD + 1),
   localparam int unsigned LW            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] en,
   input  logic [N_CH-1:0] oneshot,
   input  logic            load_valid,
   input  logic [LW-1:0]   load_ch,
   input  logic [CW-1:0]   load_period,
   output logic [N_CH-1:0] tick,
   output logic [N_CH-1:0] square,
   output logic [N_CH-1:0] active
);

   logic [CW-1:0]   cnt    [N_CH];
   logic [CW-1:0]   period [N_CH];
   logic [N_CH-1:0] armed;
   logic [N_CH-1:0] en_q;
   logic [N_CH-1:0] rearm;
   logic [CW-1:0]   load_sat;

   // Port width may exceed MAX_PERIOD when it is not 2**CW-1, hence the clamp.
   assign load_sat = (load_period > CW'(MAX_PERIOD)) ? CW'(MAX_PERIOD) : load_period;
   assign active   = en & (~oneshot | armed);
   // Only one-shot channels restart on an enable edge; periodic ones resume.
   assign rearm    = en & ~en_q & oneshot;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt[i]    <= '0;
            period[i] <= CW'(DEFAULT_PERIOD);
         end
         armed  <= '1;
         en_q   <= '0;
         tick   <= '0;
         square <= '0;
      end else begin
         en_q <= en;
         for (int i = 0; i < N_CH; i++) begin
            if (load_valid && (load_ch == LW'(i))) begin
               period[i] <= load_sat;
               cnt[i]    <= '0;
               armed[i]  <= 1'b1;
               tick[i]   <= 1'b0;
            end else if (rearm[i]) begin
               cnt[i]   <= '0;
               armed[i] <= 1'b1;
               tick[i]  <= 1'b0;
            end else if (active[i] && (cnt[i] == period[i])) begin
               cnt[i]    <= '0;
               tick[i]   <= 1'b1;
               square[i] <= ~square[i];
               armed[i]  <= ~oneshot[i];
            end else if (active[i]) begin
               cnt[i]   <= cnt[i] + CW'(1);
               tick[i]  <= 1'b0;
               armed[i] <= armed[i] | ~oneshot[i];
            end else begin
               tick[i]  <= 1'b0;
               armed[i] <= armed[i] | ~oneshot[i];
            end
         end
      end
   end

endmodule
